divide_unit: RTL and testbench

Iterative radix-2 integer divider functional unit for the out-of-order core's divide pipe. It sits directly downstream of the divide reservation station and accepts one issued `div`/`divu`/`rem`/`remu` operation at a time with operand values already read. It produces one `cdb_t` broadcast per operation and holds it until the CDB arbiter grants it. A flush input kills any in-flight work.

---
 rtl/divide_unit.sv | 153 +++++++++++++++
 tb/tb_divide_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_unit.sv
// Iterative radix-2 restoring divider for the divide pipe: one div/divu/rem/remu
// at a time, 32 BUSY cycles per normal op, result held on the CDB until granted.
package divide_unit_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] rd_v;
    logic [5:0]  rob_idx;
    logic [5:0]  pd_s;
    logic [4:0]  rd_s;
    logic [31:0] inst;
  } cdb_t;
endpackage

module divide_unit
  import divide_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [XLEN-1:0] rs1_v,
  input  logic [XLEN-1:0] rs2_v,
  input  logic [2:0]      funct3,
  input  logic [5:0]      pd_s,
  input  logic [4:0]      rd_s,
  input  logic [5:0]      rob_idx,
  input  logic [31:0]     inst,
  output cdb_t            cdb_out,
  input  logic            cdb_grant
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v,
                                              input logic is_signed);
    return (is_signed && v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  state_t          r_state, w_next;
  logic [4:0]      r_cnt;
  cdb_t            r_cdb;
  logic [1:0]      r_f3;
  logic [5:0]      r_pd, r_rob;
  logic [4:0]      r_rd;
  logic [31:0]     r_inst;
  logic            r_neg_q, r_neg_r;
  logic [XLEN-1:0] r_rem, r_quo, r_dvsr;

  logic            w_is_signed, w_div_zero, w_ovf, w_special, w_accept, w_last;
  logic [XLEN-1:0] w_sp_q, w_sp_r, w_sp_rd;
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_fin_q, w_fin_r, w_fin_rd;
  logic            w_unused_f3;

  // funct3[2] is 1 for every M-extension divide, so only bits 1:0 carry meaning
  assign w_unused_f3 = funct3[2];

  assign w_is_signed = ~funct3[0];
  assign w_div_zero  = (rs2_v == '0);
  assign w_ovf       = w_is_signed && (rs1_v == MIN_NEG) && (rs2_v == '1);
  assign w_special   = w_div_zero || w_ovf;
  assign w_accept    = issue_valid && !flush && (r_state == S_IDLE);
  assign w_last      = (r_state == S_BUSY) && (r_cnt == 5'd31);
  assign issue_ready = (r_state == S_IDLE);
  assign cdb_out     = r_cdb;

  assign w_sp_q  = w_div_zero ? '1 : MIN_NEG;
  assign w_sp_r  = w_div_zero ? rs1_v : '0;
  assign w_sp_rd = (rd_s == 5'd0) ? '0 : (funct3[1] ? w_sp_r : w_sp_q);

  // Partial remainder is below the divisor, so shift < 2*divisor and the
  // 33-bit difference sign bit alone decides the quotient bit.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvsr};
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  assign w_fin_q   = neg_if(w_quo_nxt, r_neg_q);
  assign w_fin_r   = neg_if(w_rem_nxt, r_neg_r);
  assign w_fin_rd  = (r_rd == 5'd0) ? '0 : (r_f3[1] ? w_fin_r : w_fin_q);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (cdb_grant) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_cdb   <= '0;
    end else begin
      r_state <= w_next;
      if (flush) begin
        r_cnt       <= 5'd0;
        r_cdb.valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_cnt <= 5'd0;
              if (w_special) r_cdb <= '{valid: 1'b1, rd_v: w_sp_rd, rob_idx: rob_idx,
                                        pd_s: pd_s, rd_s: rd_s, inst: inst};
            end
          end
          S_BUSY: begin
            r_cnt <= r_cnt + 5'd1;
            if (w_last) r_cdb <= '{valid: 1'b1, rd_v: w_fin_rd, rob_idx: r_rob,
                                   pd_s: r_pd, rd_s: r_rd, inst: r_inst};
          end
          S_DONE:  if (cdb_grant) r_cdb.valid <= 1'b0;
          default: r_cdb.valid <= 1'b0;
        endcase
      end
    end
  end

  // Datapath registers carry no reset; they are always reloaded at accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f3    <= funct3[1:0];
      r_pd    <= pd_s;
      r_rd    <= rd_s;
      r_rob   <= rob_idx;
      r_inst  <= inst;
      r_neg_q <= w_is_signed && (rs1_v[XLEN-1] ^ rs2_v[XLEN-1]);
      r_neg_r <= w_is_signed && rs1_v[XLEN-1];
      r_rem   <= '0;
      r_quo   <= abs_val(rs1_v, w_is_signed);
      r_dvsr  <= abs_val(rs2_v, w_is_signed);
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Directed bench for divide_unit: latency, signed/unsigned results, special
// cases, CDB backpressure, flush, async reset and rd_s=0 handling.
module tb_divide_unit;
  import divide_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, issue_valid, issue_ready, cdb_grant;
  logic [31:0] rs1_v, rs2_v, inst;
  logic [2:0]  funct3;
  logic [5:0]  pd_s, rob_idx;
  logic [4:0]  rd_s;
  cdb_t        cdb_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  divide_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .rs1_v(rs1_v), .rs2_v(rs2_v), .funct3(funct3),
    .pd_s(pd_s), .rd_s(rd_s), .rob_idx(rob_idx), .inst(inst),
    .cdb_out(cdb_out), .cdb_grant(cdb_grant)
  );

  // Presents one op on a negedge; returns on the negedge after the accept edge.
  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] pd, input logic [4:0] rd,
                          input logic [5:0] rob, input logic [31:0] ins);
    @(negedge clk);
    issue_valid = 1'b1; funct3 = f3; rs1_v = a; rs2_v = b;
    pd_s = pd; rd_s = rd; rob_idx = rob; inst = ins;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!cdb_out.valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #12;
    vecs++;
    if (cdb_out !== '0) begin
      errs++; $display("FAIL reset_cdb: got %h want 0", cdb_out);
    end
    vecs++;
    if (issue_ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready: got %b want 1", issue_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_grant_high;
    int lat;
    cdb_grant = 1'b1;
    drive_op(3'b101, 32'd100, 32'd7, 6'd9, 5'd3, 6'd5, 32'h02F757B3);
    vecs++;
    if (issue_ready !== 1'b0) begin
      errs++; $display("FAIL gh_ready_busy: got %b want 0", issue_ready);
    end
    wait_valid(lat);
    vecs++;
    if (lat !== 32) begin
      errs++; $display("FAIL gh_latency: got %0d want 32", lat);
    end
    vecs++;
    if ({cdb_out.rd_v, cdb_out.rob_idx, cdb_out.pd_s, cdb_out.rd_s, cdb_out.inst} !==
        {32'h0000000E, 6'd5, 6'd9, 5'd3, 32'h02F757B3}) begin
      errs++; $display("FAIL gh_packet: got rd_v=%h rob=%0d pd=%0d rd=%0d inst=%h want 0000000e/5/9/3/02f757b3",
                       cdb_out.rd_v, cdb_out.rob_idx, cdb_out.pd_s, cdb_out.rd_s, cdb_out.inst);
    end
    vecs++;
    if (issue_ready !== 1'b0) begin
      errs++; $display("FAIL gh_ready_done: got %b want 0", issue_ready);
    end
    @(negedge clk);
    vecs++;
    if ({cdb_out.valid, issue_ready} !== 2'b01) begin
      errs++; $display("FAIL gh_after_grant: got valid=%b ready=%b want 0/1", cdb_out.valid, issue_ready);
    end
  endtask

  task automatic test_normal_ops;
    logic [2:0]  f3 [7] = '{3'b110, 3'b100, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100};
    logic [31:0] a  [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFF9C, 32'hFFFFFF9C, 32'h80000000};
    logic [31:0] b  [7] = '{32'd3, 32'd3, 32'd1, 32'h80000000,
                            32'hFFFFFFF9, 32'hFFFFFFF9, 32'd2};
    logic [31:0] ex [7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h7FFFFFFF,
                            32'h0000000E, 32'hFFFFFFFE, 32'hC0000000};
    int lat;
    cdb_grant = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_op(f3[i], a[i], b[i], 6'd10 + 6'(i), 5'd1, 6'd20 + 6'(i), 32'h1000 + i);
      wait_valid(lat);
      vecs++;
      if (lat !== 32 || cdb_out.rd_v !== ex[i] || cdb_out.rob_idx !== 6'd20 + 6'(i)) begin
        errs++; $display("FAIL normal_%0d: got lat=%0d rd_v=%h rob=%0d want lat=32 rd_v=%h rob=%0d",
                         i, lat, cdb_out.rd_v, cdb_out.rob_idx, ex[i], 20 + i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_special;
    logic [2:0]  f3 [6] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b110, 3'b101};
    logic [31:0] a  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] b  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] ex [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFF9, 32'd0};
    int          el [6] = '{0, 0, 0, 0, 0, 32};
    int lat;
    cdb_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_op(f3[i], a[i], b[i], 6'd30, 5'd7, 6'd40 + 6'(i), 32'h2000 + i);
      wait_valid(lat);
      vecs++;
      if (lat !== el[i] || cdb_out.rd_v !== ex[i] || cdb_out.rob_idx !== 6'd40 + 6'(i)) begin
        errs++; $display("FAIL special_%0d: got lat=%0d rd_v=%h rob=%0d want lat=%0d rd_v=%h rob=%0d",
                         i, lat, cdb_out.rd_v, cdb_out.rob_idx, el[i], ex[i], 40 + i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    cdb_grant = 1'b0;
    drive_op(3'b101, 32'hFFFFFFFF, 32'h10, 6'd12, 5'd8, 6'd7, 32'hABCD0001);
    wait_valid(lat);
    vecs++;
    if (lat !== 32) begin
      errs++; $display("FAIL bp_latency: got %0d want 32", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vecs++;
      if ({cdb_out.valid, cdb_out.rd_v, cdb_out.rob_idx, cdb_out.pd_s, cdb_out.rd_s, issue_ready} !==
          {1'b1, 32'h0FFFFFFF, 6'd7, 6'd12, 5'd8, 1'b0}) begin
        errs++; $display("FAIL bp_hold_%0d: got valid=%b rd_v=%h rob=%0d ready=%b want 1/0fffffff/7/0",
                         i, cdb_out.valid, cdb_out.rd_v, cdb_out.rob_idx, issue_ready);
      end
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cdb_out.valid, issue_ready} !== 2'b01) begin
      errs++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", cdb_out.valid, issue_ready);
    end
    cdb_grant = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat;
    cdb_grant = 1'b1;
    drive_op(3'b101, 32'd1000, 32'd10, 6'd1, 5'd2, 6'd11, 32'h3000);
    wait_valid(lat);
    drive_op(3'b111, 32'd1000, 32'd7, 6'd3, 5'd4, 6'd12, 32'h3001);
    wait_valid(lat);
    vecs++;
    if (lat !== 32 || cdb_out.rd_v !== 32'd6 || cdb_out.rob_idx !== 6'd12) begin
      errs++; $display("FAIL b2b_second: got lat=%0d rd_v=%h rob=%0d want 32/00000006/12",
                       lat, cdb_out.rd_v, cdb_out.rob_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    int seen;
    cdb_grant = 1'b1;
    drive_op(3'b101, 32'd1000, 32'd3, 6'd1, 5'd1, 6'd1, 32'h4000);
    repeat (15) @(negedge clk);
    flush = 1'b1; issue_valid = 1'b1; funct3 = 3'b100; rs1_v = 32'd5; rs2_v = 32'd0;
    rob_idx = 6'd2;
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    vecs++;
    if ({cdb_out.valid, issue_ready} !== 2'b01) begin
      errs++; $display("FAIL flush_idle: got valid=%b ready=%b want 0/1", cdb_out.valid, issue_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cdb_out.valid) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++; $display("FAIL flush_no_bcast: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    cdb_grant = 1'b1;
    drive_op(3'b101, 32'd100, 32'd7, 6'd4, 5'd5, 6'd3, 32'h5000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if (cdb_out !== '0 || issue_ready !== 1'b1) begin
      errs++; $display("FAIL reset_mid: got cdb=%h ready=%b want 0/1", cdb_out, issue_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cdb_out.valid) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++; $display("FAIL reset_mid_silent: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_rd_zero;
    int lat;
    cdb_grant = 1'b1;
    drive_op(3'b101, 32'd9, 32'd3, 6'd6, 5'd0, 6'd9, 32'h6000);
    wait_valid(lat);
    vecs++;
    if (lat !== 32 || cdb_out.rd_v !== 32'd0 || cdb_out.rd_s !== 5'd0) begin
      errs++; $display("FAIL rd0_normal: got lat=%0d rd_v=%h rd_s=%0d want 32/00000000/0",
                       lat, cdb_out.rd_v, cdb_out.rd_s);
    end
    @(negedge clk);
    drive_op(3'b100, 32'd5, 32'd0, 6'd6, 5'd0, 6'd10, 32'h6001);
    wait_valid(lat);
    vecs++;
    if (lat !== 0 || cdb_out.rd_v !== 32'd0) begin
      errs++; $display("FAIL rd0_special: got lat=%0d rd_v=%h want 0/00000000", lat, cdb_out.rd_v);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; cdb_grant = 1'b0;
    rs1_v = '0; rs2_v = '0; funct3 = 3'b100; pd_s = '0; rd_s = '0; rob_idx = '0; inst = '0;
    test_reset();
    test_grant_high();
    test_normal_ops();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_rd_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
